sdram_write: RTL and testbench

//  Write-path engine downstream of the SDRAM main controller's SW arbiter. Raises w_req, and on
//  the w_en grant runs ACT -> WRITE bursts -> PRE. Emits an 18-bit command word
//  {cs_n,ras_n,cas_n,we_n,ba[1:0],a[11:0]} that is merged into the main cmd bus
//  (bits 17:14 ANDed, bits 13:0 ORed) and drives DQ write data.

---
 rtl/sdram_write_if.sv | 24 ++
 rtl/sdram_write.sv | 164 ++++++++++++++++
 tb/tb_sdram_write.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_write_if.sv
// Handshake and data bundle between the SDRAM write engine and its controller/FIFO side.
interface sdram_write_if;
  logic        wr_trig;
  logic        w_en;
  logic        ref_req;
  logic [15:0] wr_data;
  logic        w_req;
  logic        wr_data_rd;
  logic        write_data_end;
  logic        write_ref_break_end;
  logic [17:0] wr_cmd;
  logic [15:0] dq_out;
  logic        dq_oe;

  modport master (
    output wr_trig, w_en, ref_req, wr_data,
    input  w_req, wr_data_rd, write_data_end, write_ref_break_end, wr_cmd, dq_out, dq_oe
  );

  modport slave (
    input  wr_trig, w_en, ref_req, wr_data,
    output w_req, wr_data_rd, write_data_end, write_ref_break_end, wr_cmd, dq_out, dq_oe
  );
endinterface

// File: rtl/sdram_write.sv
// SDRAM write-path engine: ACT -> BURSTS_PER_TX WRITE bursts -> PRE, yielding to refresh
// at burst boundaries and resuming the remaining bursts on the next grant.
module sdram_write #(
  parameter int unsigned BURST_LEN     = 4,
  parameter int unsigned BURSTS_PER_TX = 4,
  parameter int unsigned TRCD          = 2,
  parameter int unsigned TWR           = 2,
  parameter int unsigned TRP           = 2,
  parameter logic [1:0]  BANK          = 2'b00,
  parameter logic [11:0] ROW_INIT      = 12'd0
) (
  input logic          clk,
  input logic          rst_n,
  sdram_write_if.slave bus
);

  localparam int unsigned BeatW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BurstW  = (BURSTS_PER_TX > 1) ? $clog2(BURSTS_PER_TX) : 1;
  localparam int unsigned CntW    = 4;
  localparam int unsigned TxWords = BURST_LEN * BURSTS_PER_TX;

  localparam logic [3:0] CmdIdle  = 4'b1111;
  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdAct   = 4'b0011;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdPre   = 4'b0010;

  typedef enum logic [3:0] {
    StIdle,
    StWaitGnt,
    StAct,
    StTrcd,
    StWrite,
    StTwr,
    StPre,
    StTrp,
    StEnd
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic                brk_q, brk_d;
  logic [11:0]         row_q, row_d;
  logic [8:0]          col_q, col_d;

  logic [17:0]         cmd;
  logic                rd;
  logic [8:0]          burst_off;

  assign burst_off = 9'(burst_q) << BeatW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      brk_q   <= 1'b0;
      row_q   <= ROW_INIT;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      brk_q   <= brk_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    brk_d   = brk_q;
    row_d   = row_q;
    col_d   = col_q;
    cmd     = {CmdNop, 14'd0};
    rd      = 1'b0;

    case (state_q)
      StIdle: begin
        cmd = {CmdIdle, 14'd0};
        if (bus.wr_trig) begin
          state_d = StWaitGnt;
          burst_d = '0;
          brk_d   = 1'b0;
        end
      end
      StWaitGnt: begin
        cmd = {CmdIdle, 14'd0};
        if (bus.w_en) begin
          state_d = StAct;
          beat_d  = '0;
        end
      end
      StAct: begin
        cmd     = {CmdAct, BANK, row_q};
        state_d = (TRCD > 1) ? StTrcd : StWrite;
      end
      StTrcd: begin
        if (cnt_q == CntW'(TRCD - 2)) state_d = StWrite;
      end
      StWrite: begin
        rd = 1'b1;
        if (beat_q == '0) cmd = {CmdWrite, BANK, 3'b000, col_q + burst_off};
        if (beat_q == BeatW'(BURST_LEN - 1)) begin
          beat_d = '0;
          if (burst_q == BurstW'(BURSTS_PER_TX - 1)) begin
            brk_d   = 1'b0;
            state_d = StTwr;
          end else begin
            burst_d = burst_q + 1'b1;
            // Refresh is only honoured between bursts, never mid-burst.
            if (bus.ref_req) begin
              brk_d   = 1'b1;
              state_d = StTwr;
            end
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StTwr: begin
        if (cnt_q == CntW'(TWR - 1)) state_d = StPre;
      end
      StPre: begin
        cmd     = {CmdPre, BANK, 12'h400};
        state_d = StTrp;
      end
      StTrp: begin
        if (cnt_q == CntW'(TRP - 1)) state_d = StEnd;
      end
      StEnd: begin
        if (brk_q) begin
          state_d = StWaitGnt;
        end else begin
          state_d = StIdle;
          burst_d = '0;
          col_d   = col_q + 9'(TxWords);
          if ((10'(col_q) + 10'(TxWords)) >= 10'd512) row_d = row_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Wait counter restarts on every state change, so each timed state counts from zero.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  assign bus.wr_cmd              = cmd;
  assign bus.wr_data_rd          = rd;
  assign bus.dq_oe               = rd;
  assign bus.dq_out              = rd ? bus.wr_data : 16'd0;
  assign bus.w_req               = (state_q != StIdle);
  assign bus.write_data_end      = (state_q == StEnd) && !brk_q;
  assign bus.write_ref_break_end = (state_q == StEnd) && brk_q;

endmodule

// File: tb/tb_sdram_write.sv
// Self-checking bench for sdram_write: a queue-based command schedule model checked every cycle.
module tb_sdram_write;

  localparam int BL   = 4;
  localparam int BPT  = 4;
  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;

  localparam logic [17:0] IDLE_CMD = 18'h3C000;
  localparam logic [17:0] NOP_CMD  = 18'h1C000;
  localparam logic [17:0] PRE_CMD  = 18'h08400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_write_if bus1 ();
  sdram_write_if bus2 ();

  assign bus2.wr_trig = bus1.wr_trig;
  assign bus2.w_en    = bus1.w_en;
  assign bus2.ref_req = bus1.ref_req;
  assign bus2.wr_data = bus1.wr_data;

  sdram_write dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  // Second copy whose row starts at 4095, to observe the row wrap to 0.
  sdram_write #(.ROW_INIT(12'hFFF)) dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  typedef struct {
    logic [17:0] cmd;
    logic [17:0] cmd2;
    logic        rd;
    logic        bnd;
    logic        fin;
    logic        brk;
    int          burst;
  } rec_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  rec_t        q[$];
  bit          busy     = 1'b0;
  int          resume   = 0;
  logic [11:0] row      = 12'd0;
  logic [8:0]  col      = 9'd0;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [17:0] c, input logic [17:0] c2, input logic rd,
                              input int burst, input logic bnd, input logic fin,
                              input logic brk);
    rec_t r;
    r.cmd = c; r.cmd2 = c2; r.rd = rd; r.burst = burst;
    r.bnd = bnd; r.fin = fin; r.brk = brk;
    return r;
  endfunction

  task automatic push_tail(input logic brk);
    for (int i = 0; i < TWR; i++) q.push_back(mk(NOP_CMD, NOP_CMD, 1'b0, -1, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(PRE_CMD, PRE_CMD, 1'b0, -1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < TRP; i++) q.push_back(mk(NOP_CMD, NOP_CMD, 1'b0, -1, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(NOP_CMD, NOP_CMD, 1'b0, -1, 1'b0, !brk, brk));
  endtask

  task automatic push_seg();
    logic [11:0] r2;
    logic [17:0] c;
    r2 = row - 12'd1;
    q.push_back(mk({4'b0011, 2'b00, row}, {4'b0011, 2'b00, r2}, 1'b0, -1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < TRCD - 1; i++)
      q.push_back(mk(NOP_CMD, NOP_CMD, 1'b0, -1, 1'b0, 1'b0, 1'b0));
    for (int b = resume; b < BPT; b++) begin
      for (int k = 0; k < BL; k++) begin
        c = (k == 0) ? {4'b0100, 2'b00, 3'b000, col + 9'(BL * b)} : NOP_CMD;
        q.push_back(mk(c, c, 1'b1, b, (k == BL - 1) && (b < BPT - 1), 1'b0, 1'b0));
      end
    end
    push_tail(1'b0);
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    rec_t e;
    rec_t r;
    bus1.wr_data = 16'($urandom);
    #3;
    if (q.size() > 0) e = q[0];
    else e = mk(IDLE_CMD, IDLE_CMD, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    check("wr_cmd",         bus1.wr_cmd, e.cmd);
    check("wr_cmd_wrap",    bus2.wr_cmd, e.cmd2);
    check("w_req",          18'(bus1.w_req), 18'(busy));
    check("wr_data_rd",     18'(bus1.wr_data_rd), 18'(e.rd));
    check("dq_oe",          18'(bus1.dq_oe), 18'(e.rd));
    check("dq_out",         18'(bus1.dq_out), 18'(e.rd ? bus1.wr_data : 16'd0));
    check("write_data_end", 18'(bus1.write_data_end), 18'(e.fin));
    check("ref_break_end",  18'(bus1.write_ref_break_end), 18'(e.brk));

    if (!rst_n) begin
      q.delete();
      busy = 1'b0; resume = 0; row = 12'd0; col = 9'd0;
    end else if (q.size() > 0) begin
      r = q.pop_front();
      if (r.bnd && bus1.ref_req) begin
        q.delete();
        resume = r.burst + 1;
        push_tail(1'b1);
      end
      if (r.fin) begin
        busy = 1'b0;
        col  = col + 9'd16;
        if (col == 9'd0) row = row + 12'd1;
      end
    end else if (!busy) begin
      if (bus1.wr_trig) begin
        busy = 1'b1; resume = 0;
      end
    end else if (bus1.w_en) begin
      push_seg();
    end

    @(posedge clk);
    #1;
    bus1.wr_trig = 1'b0;
    bus1.w_en    = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", 18'(q.size()), 18'd0);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus1.wr_trig = 1'b0;
    bus1.w_en    = 1'b0;
    bus1.ref_req = 1'b0;
    bus1.wr_data = 16'd0;
    @(posedge clk);
    #1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Plain transaction with a delayed grant.
    bus1.wr_trig = 1'b1;
    step();
    repeat (8) step();
    bus1.w_en = 1'b1;
    step();
    drain(60);
    repeat (3) step();

    // Refresh during the second burst forces a break, then the remainder resumes.
    bus1.wr_trig = 1'b1;
    step();
    repeat (2) step();
    bus1.w_en = 1'b1;
    step();
    n = 0;
    while (q.size() > 0 && n < 80) begin
      bus1.ref_req = (q[0].burst == 1);
      step();
      n++;
    end
    bus1.ref_req = 1'b0;
    check("break_drain", 18'(q.size()), 18'd0);
    repeat (3) step();
    bus1.w_en = 1'b1;
    step();
    drain(60);
    repeat (2) step();

    // Reset in the middle of the first burst, then a fresh transaction.
    bus1.wr_trig = 1'b1;
    step();
    bus1.w_en = 1'b1;
    step();
    n = 0;
    while (!(q.size() > 0 && q[0].burst == 0 && q[0].cmd == NOP_CMD) && n < 20) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    bus1.wr_trig = 1'b1;
    step();
    bus1.w_en = 1'b1;
    step();
    drain(60);

    // 33 randomized transactions from reset: column/row advance and wrap, ignored triggers.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 33; t++) begin
      repeat ($urandom_range(0, 2)) step();
      bus1.wr_trig = 1'b1;
      step();
      n = 0;
      while (busy && n < 400) begin
        bus1.w_en    = ($urandom_range(0, 2) == 0);
        bus1.wr_trig = ($urandom_range(0, 7) == 0);
        bus1.ref_req = ($urandom_range(0, 3) == 0);
        step();
        n++;
      end
      bus1.ref_req = 1'b0;
      check("tx_done", 18'(busy), 18'd0);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
